// File: rtl/fpu_pkg.sv
// Shared types and widths for the fpu request arbiter slice.
// Operands use a {sign, exp[6:0], mant[23:0]} 32-bit packing.
package fpu_pkg;

  localparam int FP_W     = 32;
  localparam int EXP_W    = 7;
  localparam int MANT_W   = 24;
  localparam int STATUS_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  // Index width that stays legal (>=1 bit) for any requester count.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpu_req_arbiter_if.sv
// Requester-side bus of the fpu arbiter: per-requester operand requests
// plus the shared response bus.
interface fpu_req_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import fpu_pkg::*;

  localparam int unsigned ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*FP_W-1:0] req_op_a;
  logic [NUM_REQ*FP_W-1:0] req_op_b;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [FP_W-1:0]         rsp_data;
  logic [STATUS_W-1:0]     rsp_status;
  logic [ID_W-1:0]         rsp_id;

  modport master (
    output req_valid, req_op_a, req_op_b,
    input  req_ready, rsp_valid, rsp_data, rsp_status, rsp_id
  );

  modport slave (
    input  req_valid, req_op_a, req_op_b,
    output req_ready, rsp_valid, rsp_data, rsp_status, rsp_id
  );

endinterface

// File: rtl/fpu_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping, as one-hot grant plus index.
module fpu_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] k;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = ID_W'((32'(ptr) + i) % NUM_REQ);
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Shares one fixed-latency fpu among NUM_REQ requesters: round-robin grant,
// single operation in flight, result routed back to the issuing requester.
module fpu_req_arbiter
  import fpu_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned FPU_LATENCY = 20
) (
  input  logic                clock,
  input  logic                reset,
  fpu_req_arbiter_if.slave    req_bus,
  output logic                busy,
  output logic                fpu_start,
  output logic [FP_W-1:0]     fpu_op_a,
  output logic [FP_W-1:0]     fpu_op_b,
  input  logic [FP_W-1:0]     fpu_data_in,
  input  logic [STATUS_W-1:0] fpu_status_in
);

  localparam int unsigned ID_W  = id_width(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(FPU_LATENCY + 1);

  arb_state_t          state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [ID_W-1:0]     id;
  logic [ID_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;

  fpu_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req_bus.req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_nxt         = state;
    req_bus.req_ready = '0;
    req_bus.rsp_valid = '0;
    busy              = (state != IDLE);
    unique case (state)
      IDLE: begin
        req_bus.req_ready = pick_grant;
        if (pick_any) state_nxt = ISSUE;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: if (cnt == '0) state_nxt = RESP;
      RESP: begin
        req_bus.rsp_valid = NUM_REQ'(1) << id;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // fpu_start is registered off the accept so it is high exactly in ISSUE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      cnt                <= '0;
      id                 <= '0;
      rr_ptr             <= '0;
      fpu_start          <= 1'b0;
      fpu_op_a           <= '0;
      fpu_op_b           <= '0;
      req_bus.rsp_data   <= '0;
      req_bus.rsp_status <= '0;
      req_bus.rsp_id     <= '0;
    end else begin
      state     <= state_nxt;
      fpu_start <= (state == IDLE) && pick_any;
      unique case (state)
        IDLE: if (pick_any) begin
          fpu_op_a <= req_bus.req_op_a[FP_W * int'(pick_idx) +: FP_W];
          fpu_op_b <= req_bus.req_op_b[FP_W * int'(pick_idx) +: FP_W];
          id       <= pick_idx;
        end
        ISSUE: cnt <= CNT_W'(FPU_LATENCY - 1);
        WAIT: begin
          if (cnt == '0) begin
            req_bus.rsp_data   <= fpu_data_in;
            req_bus.rsp_status <= fpu_status_in;
            req_bus.rsp_id     <= id;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: rr_ptr <= (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Randomized bench for fpu_req_arbiter against a transaction-schedule model;
// the fpu is a fixed-latency stand-in whose output is junk outside its valid cycle.
module tb_fpu_req_arbiter;
  import fpu_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned L = 20;
  localparam int PH1_END  = 30;
  localparam int PH2_END  = PH1_END + 23 * 8;
  localparam int PH3_END  = PH2_END + 23 * 6;
  localparam int NCYC     = 1800;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        busy, fpu_start;
  logic [31:0] fpu_op_a, fpu_op_b, fpu_data_in;
  logic [3:0]  fpu_status_in;

  fpu_req_arbiter_if #(.NUM_REQ(N)) bus ();

  fpu_req_arbiter #(
    .NUM_REQ     (N),
    .FPU_LATENCY (L)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_bus       (bus),
    .busy          (busy),
    .fpu_start     (fpu_start),
    .fpu_op_a      (fpu_op_a),
    .fpu_op_b      (fpu_op_b),
    .fpu_data_in   (fpu_data_in),
    .fpu_status_in (fpu_status_in)
  );

  function automatic logic [35:0] fpu_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    logic [3:0]  s;
    d = {a[31] ^ b[31], a[30:0] + {b[29:0], b[30]}};
    s = a[3:0] ^ b[31:28] ^ 4'h5;
    return {s, d};
  endfunction

  // Stand-in fpu: result visible only in the cycle start+L.
  logic        pv [L];
  logic [35:0] pd [L];
  logic [35:0] junk;
  always @(posedge clock) begin
    pv[0] <= fpu_start;
    pd[0] <= fpu_ref(fpu_op_a, fpu_op_b);
    for (int k = L - 1; k > 0; k--) begin
      pv[k] <= pv[k-1];
      pd[k] <= pd[k-1];
    end
    junk <= {4'($urandom), $urandom};
  end
  assign {fpu_status_in, fpu_data_in} = (pv[L-1] === 1'b1) ? pd[L-1] : junk;

  int n_total = 0;
  int n_bad   = 0;
  int c       = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, c, got, exp);
    end
  endtask

  // Requester state
  logic [N-1:0] pend;
  logic [31:0]  pa [N];
  logic [31:0]  pb [N];
  logic [N-1:0] gr_last;

  // Model state
  int          free_at, start_cyc, rsp_cyc, acc_cyc;
  int unsigned ptr, fid, g, k;
  logic        found;
  logic [31:0] fa, fb, op_a_exp, op_b_exp, last_d;
  logic [3:0]  last_s;
  int unsigned last_id;
  logic [N-1:0] exp_ready, sh;
  logic        rst_now, rst_done;
  logic [N*32-1:0] ta, tb_b;

  task automatic model_reset();
    ptr       = 0;
    free_at   = c;
    start_cyc = -100;
    rsp_cyc   = -100;
    acc_cyc   = -100;
    last_d    = '0;
    last_s    = '0;
    last_id   = 0;
    op_a_exp  = '0;
    op_b_exp  = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      ta[i*32 +: 32]   = pa[i];
      tb_b[i*32 +: 32] = pb[i];
    end
    bus.req_valid = pend;
    bus.req_op_a  = ta;
    bus.req_op_b  = tb_b;
  endtask

  initial begin
    pend     = '0;
    gr_last  = '0;
    rst_now  = 1'b1;
    rst_done = 1'b0;
    fid      = 0;
    fa       = '0;
    fb       = '0;
    for (int i = 0; i < N; i++) begin
      pa[i] = '0;
      pb[i] = '0;
    end
    drive();
    repeat (3) @(posedge clock);

    for (c = 0; c < NCYC; c++) begin
      @(posedge clock);
      #1;
      if (rst_now) begin
        model_reset();
        rst_now = 1'b0;
      end
      reset = 1'b0;

      for (int i = 0; i < N; i++) begin
        if (gr_last[i]) begin
          pend[i] = 1'b0;
          pa[i]   = (c < PH1_END && i == 1) ? 32'h3F8CCCCD : $urandom;
          pb[i]   = (c < PH1_END && i == 1) ? 32'h3F8CCCCD : $urandom;
        end
        if (c < PH1_END) begin
          if (c == 0 && i == 0) begin
            pend[0] = 1'b1; pa[0] = 32'h40000000; pb[0] = 32'h3FC00000;
          end
          if (c == 25 && i == 1) begin
            pend[1] = 1'b1; pa[1] = 32'h3F800000; pb[1] = 32'hBF800000;
          end
        end else if (c < PH2_END) begin
          pend[i] = 1'b1;
        end else if (c < PH3_END) begin
          pend[i] = (i == 0 || i == 2);
        end else if (pend[i]) begin
          if ($urandom_range(0, 29) == 0) pend[i] = 1'b0;
        end else if ($urandom_range(0, 9) == 0) begin
          pend[i] = 1'b1; pa[i] = $urandom; pb[i] = $urandom;
        end
      end
      gr_last = '0;

      // Single reset pulse deep inside a WAIT phase of the random section.
      if (!rst_done && c >= PH3_END && c == acc_cyc + 10) begin
        reset    = 1'b1;
        pend     = '0;
        rst_done = 1'b1;
        rst_now  = 1'b1;
      end
      drive();
      #1;

      if (!rst_now) begin
        exp_ready = '0;
        if (c >= free_at && pend != '0) begin
          found = 1'b0;
          g     = 0;
          for (int i = 0; i < N; i++) begin
            k  = (ptr + i) % N;
            sh = pend >> k;
            if (!found && sh[0]) begin
              found = 1'b1;
              g     = k;
            end
          end
          exp_ready = N'(1) << g;
          acc_cyc   = c;
          start_cyc = c + 1;
          rsp_cyc   = c + L + 2;
          free_at   = c + L + 3;
          fid       = g;
          fa        = pa[g];
          fb        = pb[g];
          ptr       = (g + 1) % N;
        end
        if (c == rsp_cyc) begin
          {last_s, last_d} = fpu_ref(fa, fb);
          last_id          = fid;
        end

        chk("req_ready",  64'(bus.req_ready), 64'(exp_ready));
        chk("fpu_start",  64'(fpu_start), 64'(c == start_cyc));
        chk("busy",       64'(busy), 64'(c >= start_cyc && c <= rsp_cyc));
        chk("rsp_valid",  64'(bus.rsp_valid), (c == rsp_cyc) ? 64'(N'(1) << fid) : 64'(0));
        chk("rsp_data",   64'(bus.rsp_data), 64'(last_d));
        chk("rsp_status", 64'(bus.rsp_status), 64'(last_s));
        chk("rsp_id",     64'(bus.rsp_id), 64'(last_id));
        chk("fpu_op_a",   64'(fpu_op_a), 64'(op_a_exp));
        chk("fpu_op_b",   64'(fpu_op_b), 64'(op_b_exp));

        if (exp_ready != '0) begin
          op_a_exp = fa;
          op_b_exp = fb;
        end
        gr_last = exp_ready;
      end
    end

    chk("reset_injected", 64'(rst_done), 64'(1));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
